// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus a transmit sequencer that feeds uart_tx one byte per frame
// through its start_tx/data/ready handshake, exposing level and sticky overflow.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          user_clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          ovf_clr,
    input  logic          tx_ready,
    output logic          start_tx,
    output logic [7:0]    tx_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic          full_q, empty_q, ovf_q, ovf_d;
    logic          start_q, busy_q;
    logic [7:0]    tx_data_q;
    state_t        state_q, state_d;
    logic          push, pop;

    // Pop only from S_IDLE, so an unknown state can never launch a frame.
    assign push = wr_en && !full_q;
    assign pop  = (state_q == S_IDLE) && !empty_q && tx_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (pop) state_d = S_ISSUE;
            S_ISSUE:     state_d = S_WAIT_BUSY;
            // uart_tx's ready lags its capture by two cycles; a high ready here is stale.
            S_WAIT_BUSY: if (!tx_ready) state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (tx_ready) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // A new overflow outranks a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_en && full_q)
            ovf_d = 1'b1;
        else if (ovf_clr)
            ovf_d = 1'b0;
    end

    always_ff @(posedge user_clk) begin
        if (push)
            mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge user_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            full_q  <= (level_d == FULL_LEVEL);
            empty_q <= (level_d == '0);
            ovf_q   <= ovf_d;
            start_q <= pop;
            busy_q  <= (state_d != S_IDLE);
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                tx_data_q <= mem[rd_ptr_q];
            end
        end
    end

    assign start_tx = start_q;
    assign tx_data  = tx_data_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;
    assign overflow = ovf_q;
    assign busy     = busy_q;

endmodule
